// File: rtl/fifo_v2_if.sv
// fifo_v2_if: request/response bundle for the fifo_v2 buffer.
// master drives requests, slave (the FIFO) drives status and data.
interface fifo_v2_if #(
  parameter int DataWidth = 32,
  parameter int Depth     = 8,
  parameter int PtrWidth  = $clog2(Depth)
);
  logic                 writeEn;
  logic [DataWidth-1:0] writeData;
  logic                 readEn;
  logic                 clearErr;
  logic [DataWidth-1:0] readData;
  logic                 full;
  logic                 empty;
  logic                 almostFull;
  logic                 almostEmpty;
  logic [PtrWidth:0]    count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output writeEn, writeData, readEn, clearErr,
    input  readData, full, empty, almostFull,
    input  almostEmpty, count, overflow, underflow
  );

  modport slave (
    input  writeEn, writeData, readEn, clearErr,
    output readData, full, empty, almostFull,
    output almostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_v2.sv
// fifo_v2: single-clock FIFO, wrap-bit pointers, sticky errors.
// Define FIFO_V2_FWFT_EN for first-word-fall-through reads.
module fifo_v2 #(
  parameter int DataWidth = 32,
  parameter int Depth     = 8,
  parameter int AfThr     = 6,
  parameter int AeThr     = 2,
  parameter int PtrWidth  = $clog2(Depth)
) (
  input  logic     clk,
  input  logic     rstN,
  fifo_v2_if.slave bus
);

  localparam logic [PtrWidth:0] LAf = (PtrWidth+1)'(AfThr);
  localparam logic [PtrWidth:0] LAe = (PtrWidth+1)'(AeThr);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrWidth:0]    r_wr_ptr;
  logic [PtrWidth:0]    r_rd_ptr;
  logic                 r_ovf;
  logic                 r_unf;

  logic [PtrWidth:0]    w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [DataWidth-1:0] w_rdata;
  logic [PtrWidth-1:0]  w_wr_addr;
  logic [PtrWidth-1:0]  w_rd_addr;

  assign w_wr_addr = r_wr_ptr[PtrWidth-1:0];
  assign w_rd_addr = r_rd_ptr[PtrWidth-1:0];

  assign w_full  = (r_wr_ptr[PtrWidth] != r_rd_ptr[PtrWidth])
                && (w_wr_addr == w_rd_addr);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign w_wr_acc = bus.writeEn && !w_full;
  assign w_rd_acc = bus.readEn && !w_empty;

  // Storage is not reset; stale words are unreachable behind the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= bus.writeData;
    end
  end

  // Pointer advance on accepted requests only.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sticky error flags; a new error beats a coincident clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.writeEn && w_full) r_ovf <= 1'b1;
      else if (bus.clearErr)     r_ovf <= 1'b0;
      if (bus.readEn && w_empty) r_unf <= 1'b1;
      else if (bus.clearErr)     r_unf <= 1'b0;
    end
  end

`ifdef FIFO_V2_FWFT_EN
  assign w_rdata = w_empty ? '0 : r_mem[w_rd_addr];
`else
  logic [DataWidth-1:0] r_rdata;

  // Registered read port: loads the head word when a read is accepted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  assign w_rdata = r_rdata;
`endif

  assign bus.readData    = w_rdata;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = w_count;
  assign bus.almostFull  = (w_count >= LAf);
  assign bus.almostEmpty = (w_count <= LAe);
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_unf;

endmodule

// File: tb/tb_fifo_v2.sv
// tb_fifo_v2: table vectors, directed corners and random traffic
// against a queue-based reference of the FIFO.
module tb_fifo_v2;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  fifo_v2_if #(.DataWidth(32), .Depth(8)) bus ();

  fifo_v2 #(
    .DataWidth(32),
    .Depth(8),
    .AfThr(6),
    .AeThr(2)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [31:0] m_rd = 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        ce;
    int          cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        unf;
    logic [31:0] rd_std;
    logic [31:0] rd_fwft;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd();
`ifdef FIFO_V2_FWFT_EN
    return (q.size() != 0) ? q[0] : 32'h0;
`else
    return m_rd;
`endif
  endfunction

  task automatic check_model(input string t);
    int n;
    n = q.size();
    chk({t, ".cnt"}, 64'(bus.count), 64'(n));
    chk({t, ".full"}, 64'(bus.full), 64'(n == 8));
    chk({t, ".empty"}, 64'(bus.empty), 64'(n == 0));
    chk({t, ".af"}, 64'(bus.almostFull), 64'(n >= 6));
    chk({t, ".ae"}, 64'(bus.almostEmpty), 64'(n <= 2));
    chk({t, ".ovf"}, 64'(bus.overflow), 64'(m_ovf));
    chk({t, ".unf"}, 64'(bus.underflow), 64'(m_unf));
    chk({t, ".rd"}, 64'(bus.readData), 64'(exp_rd()));
  endtask

  task automatic step(input logic we, input logic [31:0] wd,
                      input logic re, input logic ce);
    int n;
    bus.writeEn = we;
    bus.writeData = wd;
    bus.readEn = re;
    bus.clearErr = ce;
    @(posedge clk);
    n = q.size();
    if (we && n == 8) m_ovf = 1'b1;
    else if (ce) m_ovf = 1'b0;
    if (re && n == 0) m_unf = 1'b1;
    else if (ce) m_unf = 1'b0;
    if (re && n > 0) m_rd = q.pop_front();
    if (we && n < 8) q.push_back(wd);
    #1;
    bus.writeEn = 1'b0;
    bus.readEn = 1'b0;
    bus.clearErr = 1'b0;
    check_model("mdl");
  endtask

  task automatic do_reset();
    bus.writeEn = 1'b0;
    bus.readEn = 1'b0;
    bus.clearErr = 1'b0;
    #2 rstN = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd = 32'h0;
    #1;
    chk("rst.cnt", 64'(bus.count), 64'd0);
    chk("rst.empty", 64'(bus.empty), 64'd1);
    chk("rst.full", 64'(bus.full), 64'd0);
    chk("rst.ae", 64'(bus.almostEmpty), 64'd1);
    chk("rst.af", 64'(bus.almostFull), 64'd0);
    chk("rst.ovf", 64'(bus.overflow), 64'd0);
    chk("rst.unf", 64'(bus.underflow), 64'd0);
    chk("rst.rd", 64'(bus.readData), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic we, input logic [31:0] wd, input logic re,
    input logic ce, input int cnt, input logic full,
    input logic empty, input logic af, input logic ae,
    input logic ovf, input logic unf,
    input logic [31:0] rd_std, input logic [31:0] rd_fwft);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.ce = ce;
    v.cnt = cnt; v.full = full; v.empty = empty;
    v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    v.rd_std = rd_std; v.rd_fwft = rd_fwft;
    return v;
  endfunction

  initial begin
    logic [31:0] rv;
    logic [31:0] exp_v;

    for (int i = 0; i < 8; i++) begin
      tv[i] = mk(1, 32'h10 + i, 0, 0, i + 1, i == 7, 0,
                 (i + 1) >= 6, (i + 1) <= 2, 0, 0, 32'h0, 32'h10);
    end
    tv[8]  = mk(1, 32'hDEAD, 0, 0, 8, 1, 0, 1, 0, 1, 0, 32'h0, 32'h10);
    tv[9]  = mk(0, 32'h0, 0, 1, 8, 1, 0, 1, 0, 0, 0, 32'h0, 32'h10);
    tv[10] = mk(1, 32'hBEEF, 0, 1, 8, 1, 0, 1, 0, 1, 0, 32'h0, 32'h10);
    tv[11] = mk(0, 32'h0, 0, 1, 8, 1, 0, 1, 0, 0, 0, 32'h0, 32'h10);
    for (int k = 0; k < 8; k++) begin
      tv[12 + k] = mk(0, 32'h0, 1, 0, 7 - k, 0, k == 7,
                      (7 - k) >= 6, (7 - k) <= 2, 0, 0,
                      32'h10 + k, (k < 7) ? 32'h11 + k : 32'h0);
    end
    tv[20] = mk(0, 32'h0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 32'h17, 32'h0);
    tv[21] = mk(1, 32'h55, 1, 0, 1, 0, 0, 0, 1, 0, 1, 32'h17, 32'h55);
    tv[22] = mk(0, 32'h0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h17, 32'h55);

    bus.writeEn = 1'b0;
    bus.writeData = 32'h0;
    bus.readEn = 1'b0;
    bus.clearErr = 1'b0;
    #1;
    do_reset();

    // Fill, overflow, clear, drain, underflow, both-at-empty.
    for (int i = 0; i < 23; i++) begin
      step(tv[i].we, tv[i].wd, tv[i].re, tv[i].ce);
      chk($sformatf("tv%0d.cnt", i), 64'(bus.count), 64'(tv[i].cnt));
      chk($sformatf("tv%0d.full", i), 64'(bus.full), 64'(tv[i].full));
      chk($sformatf("tv%0d.empty", i), 64'(bus.empty), 64'(tv[i].empty));
      chk($sformatf("tv%0d.af", i), 64'(bus.almostFull), 64'(tv[i].af));
      chk($sformatf("tv%0d.ae", i), 64'(bus.almostEmpty), 64'(tv[i].ae));
      chk($sformatf("tv%0d.ovf", i), 64'(bus.overflow), 64'(tv[i].ovf));
      chk($sformatf("tv%0d.unf", i), 64'(bus.underflow), 64'(tv[i].unf));
`ifdef FIFO_V2_FWFT_EN
      chk($sformatf("tv%0d.rd", i), 64'(bus.readData), 64'(tv[i].rd_fwft));
`else
      chk($sformatf("tv%0d.rd", i), 64'(bus.readData), 64'(tv[i].rd_std));
`endif
    end

    // Full with both requests: only the read goes through.
    for (int i = 0; i < 7; i++) step(1, 32'h200 + i, 0, 0);
    chk("full.pre", 64'(bus.full), 64'd1);
    step(1, 32'hBAD0, 1, 0);
    chk("fullboth.cnt", 64'(bus.count), 64'd7);
    chk("fullboth.ovf", 64'(bus.overflow), 64'd1);
    chk("fullboth.full", 64'(bus.full), 64'd0);
    step(0, 32'h0, 0, 1);
    chk("clr.ovf", 64'(bus.overflow), 64'd0);

    // Steady read+write at count 4; pointers wrap several times.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h300 + i, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom, 1, 0);
      chk($sformatf("steady%0d.cnt", i), 64'(bus.count), 64'd4);
    end

    // Reset in the middle of a burst at count 5.
    step(1, 32'h400, 0, 0);
    step(1, 32'h401, 0, 0);
    step(0, 32'h0, 1, 0);
    chk("mid.cnt", 64'(bus.count), 64'd5);
    do_reset();
    exp_v = 32'hA5A5_0001;
    step(1, exp_v, 0, 0);
    chk("addr0.mem", 64'(dut.r_mem[0]), 64'(exp_v));
`ifdef FIFO_V2_FWFT_EN
    chk("addr0.rd", 64'(bus.readData), 64'(exp_v));
    step(0, 32'h0, 1, 0);
`else
    step(0, 32'h0, 1, 0);
    chk("addr0.rd", 64'(bus.readData), 64'(exp_v));
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      rv = $urandom;
      step($urandom_range(0, 99) < 55, rv,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
